change_dispenser: RTL

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/change_dispenser.sv
// Change dispenser: pays out 100-yen coins from a hopper one at a time, confirming
// each coin on the exit sensor, with jam timeout, empty stall and refill handling.
module change_dispenser #(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned GAP_CYCLES     = 4,
  parameter logic [7:0]  INIT_COINS     = 8'd0
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_change_valid,
  input  logic [4:0] i_change_amount,
  output logic       o_change_ready,
  output logic       o_hopper_eject,
  input  logic       i_hopper_coin_sensed,
  input  logic       i_refill_valid,
  input  logic [7:0] i_refill_count,
  input  logic       i_clear_error,
  output logic       o_pop_100_yen_coin,
  output logic [4:0] o_coins_owed,
  output logic [7:0] o_inventory,
  output logic       o_jam_error,
  output logic       o_empty_error
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_EJECT      = 3'd1,
    S_WAIT_SENSE = 3'd2,
    S_GAP        = 3'd3,
    S_EMPTY      = 3'd4,
    S_JAM        = 3'd5
  } state_t;

  // Both timers count from 0, so the terminal value is the cycle count minus one.
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] GAP_LAST     = 16'(GAP_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_timer;
  logic [15:0] w_timer_next;
  logic [4:0]  r_coins_owed;
  logic [4:0]  w_owed_next;
  logic [7:0]  r_inventory;
  logic [7:0]  w_inventory_next;
  logic [8:0]  w_inv_sum;
  logic [8:0]  w_inv_dec;
  logic        w_coin_taken;
  logic        w_eject_next;
  logic        w_pop_next;
  logic        r_hopper_eject;
  logic        r_pop;
  logic        r_change_ready;
  logic        r_jam_error;
  logic        r_empty_error;

  // Next-state, timer, owed count and pulse requests.
  always_comb begin
    w_state_next = r_state;
    w_timer_next = r_timer;
    w_owed_next  = r_coins_owed;
    w_eject_next = 1'b0;
    w_pop_next   = 1'b0;
    w_coin_taken = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_change_valid && (i_change_amount != 5'd0)) begin
          w_owed_next  = i_change_amount;
          w_state_next = S_EJECT;
        end else begin
          w_state_next = S_IDLE;
        end
      end
      S_EJECT: begin
        if (r_inventory != 8'd0) begin
          w_eject_next = 1'b1;
          w_timer_next = 16'd0;
          w_state_next = S_WAIT_SENSE;
        end else begin
          w_state_next = S_EMPTY;
        end
      end
      S_WAIT_SENSE: begin
        // A sense arriving together with the last timeout count still wins.
        if (i_hopper_coin_sensed) begin
          w_coin_taken = 1'b1;
          w_pop_next   = 1'b1;
          w_owed_next  = r_coins_owed - 5'd1;
          w_timer_next = 16'd0;
          if (r_coins_owed <= 5'd1) begin
            w_state_next = S_IDLE;
          end else begin
            w_state_next = S_GAP;
          end
        end else if (r_timer == TIMEOUT_LAST) begin
          w_timer_next = 16'd0;
          w_state_next = S_JAM;
        end else begin
          w_timer_next = r_timer + 16'd1;
        end
      end
      S_GAP: begin
        if (r_timer == GAP_LAST) begin
          w_timer_next = 16'd0;
          w_state_next = S_EJECT;
        end else begin
          w_timer_next = r_timer + 16'd1;
        end
      end
      S_EMPTY: begin
        if (r_inventory != 8'd0) begin
          w_state_next = S_EJECT;
        end else begin
          w_state_next = S_EMPTY;
        end
      end
      S_JAM: begin
        if (i_clear_error) begin
          w_state_next = (r_coins_owed != 5'd0) ? S_EJECT : S_IDLE;
        end else begin
          w_state_next = S_JAM;
        end
      end
      default: begin
        w_state_next = S_IDLE;
        w_timer_next = 16'd0;
      end
    endcase
  end

  // Inventory: refill and coin decrement combine, floored at 0 and saturated at 255.
  always_comb begin
    w_inv_sum = {1'b0, r_inventory} + (i_refill_valid ? {1'b0, i_refill_count} : 9'd0);
    if (w_coin_taken && (w_inv_sum != 9'd0)) begin
      w_inv_dec = w_inv_sum - 9'd1;
    end else begin
      w_inv_dec = w_inv_sum;
    end
    if (w_inv_dec > 9'd255) begin
      w_inventory_next = 8'd255;
    end else begin
      w_inventory_next = w_inv_dec[7:0];
    end
  end

  // State, counters and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_IDLE;
      r_timer        <= 16'd0;
      r_coins_owed   <= 5'd0;
      r_inventory    <= INIT_COINS;
      r_hopper_eject <= 1'b0;
      r_pop          <= 1'b0;
      r_change_ready <= 1'b1;
      r_jam_error    <= 1'b0;
      r_empty_error  <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_timer        <= w_timer_next;
      r_coins_owed   <= w_owed_next;
      r_inventory    <= w_inventory_next;
      r_hopper_eject <= w_eject_next;
      r_pop          <= w_pop_next;
      r_change_ready <= (w_state_next == S_IDLE);
      r_jam_error    <= (w_state_next == S_JAM);
      r_empty_error  <= (w_state_next == S_EMPTY);
    end
  end

  assign o_change_ready     = r_change_ready;
  assign o_hopper_eject     = r_hopper_eject;
  assign o_pop_100_yen_coin = r_pop;
  assign o_coins_owed       = r_coins_owed;
  assign o_inventory        = r_inventory;
  assign o_jam_error        = r_jam_error;
  assign o_empty_error      = r_empty_error;

endmodule
